// File: rtl/mips_register_file_pkg.sv
// -----------------------------------------------------------------------------
// mips_register_file_pkg
//   Shared definitions for the MIPS general-purpose register file:
//   default geometry (DATA_W, ADDR_W, NUM_REGS), architectural register index
//   names, and the read-port identifiers used to index the two read mux trees.
// -----------------------------------------------------------------------------
package mips_register_file_pkg;

  // Default geometry of the register file.
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // Architectural register indices referenced by the datapath and software.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  // The two independent read ports.
  typedef enum logic [0:0] {
    READ_PORT_RS = 1'b0,
    READ_PORT_RT = 1'b1
  } read_port_e;

  localparam int NUM_READ_PORTS = 2;

endpackage : mips_register_file_pkg

// File: rtl/mips_register_file_if.sv
// -----------------------------------------------------------------------------
// mips_register_file_if
//   Bus between the single-cycle datapath and the register file.
//   Signals:
//     reg_write  RegWrite control (write enable)
//     rs_addr    read port A index
//     rt_addr    read port B index
//     wr_addr    write index (RegDst mux output)
//     wr_data    write data (MemtoReg mux output)
//     rs_data    read port A data
//     rt_data    read port B data
//   Modports:
//     master  datapath side: drives control/addresses/data, receives read data
//     slave   register file side
// -----------------------------------------------------------------------------
interface mips_register_file_if
  import mips_register_file_pkg::*;
#(
  parameter int DATA_W = mips_register_file_pkg::DATA_W,
  parameter int ADDR_W = mips_register_file_pkg::ADDR_W
);

  logic              reg_write;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  modport master (
    output reg_write,
    output rs_addr,
    output rt_addr,
    output wr_addr,
    output wr_data,
    input  rs_data,
    input  rt_data
  );

  modport slave (
    input  reg_write,
    input  rs_addr,
    input  rt_addr,
    input  wr_addr,
    input  wr_data,
    output rs_data,
    output rt_data
  );

endinterface : mips_register_file_if

// File: rtl/mips_register_file_reg32_en.sv
// -----------------------------------------------------------------------------
// mips_register_file_reg32_en
//   One general-purpose register: W-bit storage with asynchronous active-low
//   clear and a load enable.
//   Ports:
//     clk    clock, loads on rising edge
//     rst_n  asynchronous active-low clear
//     en_i   load enable (already qualified with RegWrite and index decode)
//     d_i    data to load
//     q_o    stored value
// -----------------------------------------------------------------------------
module mips_register_file_reg32_en #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = en_i ? d_i : data_q;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge; blocking here would create
  // order-dependent simulation races between instances.
  // NOTE: every storage word is reset. The register file has no X tolerance,
  // so unlike a RAM macro each word gets an explicit clear value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : mips_register_file_reg32_en

// File: rtl/mips_register_file.sv
// -----------------------------------------------------------------------------
// mips_register_file
//   32 x 32-bit MIPS general-purpose register file for the single-cycle
//   datapath. One synchronous write port, two combinational read ports.
//   Register 0 ($zero) has no storage: its read-mux leaf is tied to zero and
//   writes to it are never decoded.
//   Ports:
//     clk    clock, all writes on rising edge
//     rst_n  asynchronous active-low reset, clears every register
//     rf     mips_register_file_if.slave
//              reg_write/wr_addr/wr_data : write port
//              rs_addr -> rs_data        : read port A
//              rt_addr -> rt_data        : read port B
//   Reads are zero-latency with no write bypass: a read of the index being
//   written returns the old value until the clock edge.
// -----------------------------------------------------------------------------
module mips_register_file
  import mips_register_file_pkg::*;
#(
  parameter int DATA_W   = mips_register_file_pkg::DATA_W,
  parameter int ADDR_W   = mips_register_file_pkg::ADDR_W,
  parameter int NUM_REGS = mips_register_file_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_register_file_if.slave rf
);

  // The read trees are full binary trees over the index bits, so the register
  // count must fill the index space exactly.
  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_geometry
    $error("mips_register_file: NUM_REGS must equal 2**ADDR_W");
  end

  // ---------------------------------------------------------------------------
  // Write enable decode: one-hot of wr_addr qualified by reg_write. Index 0 is
  // never decoded, which is what discards writes to $zero.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:1] we;

  // NOTE: the decode output gets a default before the loop so every bit is
  // assigned on every path; otherwise synthesis infers latches.
  always_comb begin
    we = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rf.reg_write && (rf.wr_addr == ADDR_W'(i))) begin
        we[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: registers 1..NUM_REGS-1. leaf[0] is the hardwired $zero input of
  // both read trees.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] leaf [NUM_REGS];

  assign leaf[REG_ZERO] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    mips_register_file_reg32_en #(
      .W (DATA_W)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (we[g]),
      .d_i   (rf.wr_data),
      .q_o   (leaf[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Read ports: one 2:1-mux tree per port, ADDR_W levels deep. Level l halves
  // the candidates using address bit l-1, so the first level resolves the LSB
  // (pairs 2j/2j+1) and the root resolves the MSB.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [NUM_READ_PORTS];
  logic [DATA_W-1:0] rd_data [NUM_READ_PORTS];

  assign rd_addr[READ_PORT_RS] = rf.rs_addr;
  assign rd_addr[READ_PORT_RT] = rf.rt_addr;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    for (genvar l = 0; l <= ADDR_W; l++) begin : g_lvl
      localparam int N = NUM_REGS >> l;
      logic [DATA_W-1:0] v [N];

      if (l == 0) begin : g_leaves
        for (genvar j = 0; j < N; j++) begin : g_in
          assign v[j] = leaf[j];
        end
      end else begin : g_mux
        for (genvar j = 0; j < N; j++) begin : g_m2
          assign v[j] = rd_addr[p][l-1] ? g_lvl[l-1].v[2*j+1]
                                        : g_lvl[l-1].v[2*j];
        end
      end
    end

    assign rd_data[p] = g_lvl[ADDR_W].v[0];
  end

  assign rf.rs_data = rd_data[READ_PORT_RS];
  assign rf.rt_data = rd_data[READ_PORT_RT];

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// -----------------------------------------------------------------------------
// tb_mips_register_file
//   Self-checking bench for mips_register_file. A plain array holds the
//   architectural register contents; reads are compared against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mips_register_file;
  import mips_register_file_pkg::*;

  logic clk;
  logic rst_n;

  mips_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

  mips_register_file #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Architectural view: index 0 is never written, so it always holds 0.
  logic [31:0] model [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Write one register through a full clock cycle.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rf_if.reg_write = 1'b1;
    rf_if.wr_addr   = addr;
    rf_if.wr_data   = data;
    @(posedge clk);
    if (rst_n && addr != 5'd0) model[addr] = data;
    #1;
    rf_if.reg_write = 1'b0;
  endtask

  // Drive both read addresses and compare against the model.
  task automatic check_pair(input string tag, input logic [4:0] a, input logic [4:0] b);
    rf_if.rs_addr = a;
    rf_if.rt_addr = b;
    #1;
    check({tag, "_rs"}, rf_if.rs_data, model[a]);
    check({tag, "_rt"}, rf_if.rt_data, model[b]);
  endtask

  initial begin
    rst_n           = 1'b0;
    rf_if.reg_write = 1'b0;
    rf_if.rs_addr   = '0;
    rf_if.rt_addr   = '0;
    rf_if.wr_addr   = '0;
    rf_if.wr_data   = '0;
    model_clear();

    // Power-on reset: every index reads zero on both ports.
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rf_if.rs_addr = 5'(i);
      rf_if.rt_addr = 5'(31 - i);
      #0.1;
      check("por_rs", rf_if.rs_data, 32'h0);
      check("por_rt", rf_if.rt_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every register with random data, then assert reset mid-cycle.
    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom());
    check_pair("fill", 5'd7, 5'd30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      rf_if.rs_addr = 5'(i);
      rf_if.rt_addr = 5'(i);
      #0.1;
      check("async_rst_rs", rf_if.rs_data, 32'h0);
      check("async_rst_rt", rf_if.rt_data, 32'h0);
    end
    // Release reset mid-cycle; contents stay zero with no writes.
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_pair("post_release", 5'd8, 5'd31);

    // Disabled write to r5 leaves it at zero.
    @(negedge clk);
    rf_if.reg_write = 1'b0;
    rf_if.wr_addr   = 5'd5;
    rf_if.wr_data   = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    rf_if.rs_addr = 5'd5;
    #1;
    check("disabled_write_r5", rf_if.rs_data, 32'h0);

    // Two writes, then both values read in the same cycle.
    do_write(5'd8, 32'hDEAD_BEEF);
    do_write(REG_RA, 32'h1234_5678);
    rf_if.rs_addr = 5'd8;
    rf_if.rt_addr = REG_RA;
    #1;
    check("r8_rs", rf_if.rs_data, 32'hDEAD_BEEF);
    check("r31_rt", rf_if.rt_data, 32'h1234_5678);

    // Same index on both ports.
    rf_if.rt_addr = 5'd8;
    #1;
    check("same_idx_rt", rf_if.rt_data, 32'hDEAD_BEEF);

    // $zero ignores writes.
    do_write(REG_ZERO, 32'hFFFF_FFFF);
    rf_if.rs_addr = REG_ZERO;
    rf_if.rt_addr = REG_ZERO;
    #1;
    check("zero_rs", rf_if.rs_data, 32'h0);
    check("zero_rt", rf_if.rt_data, 32'h0);

    // Read during write: old value before the edge, new value after.
    do_write(5'd9, 32'h1);
    @(negedge clk);
    rf_if.reg_write = 1'b1;
    rf_if.wr_addr   = 5'd9;
    rf_if.wr_data   = 32'h2;
    rf_if.rs_addr   = 5'd9;
    #1;
    check("rdw_before", rf_if.rs_data, 32'h1);
    @(posedge clk);
    model[9] = 32'h2;
    #1;
    rf_if.reg_write = 1'b0;
    check("rdw_after", rf_if.rs_data, 32'h2);

    // Reset coincident with a write: reset wins.
    do_write(REG_SP, 32'hCAFE_0001);
    @(negedge clk);
    rf_if.reg_write = 1'b1;
    rf_if.wr_addr   = 5'd3;
    rf_if.wr_data   = 32'h77;
    rst_n           = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rf_if.rs_addr = 5'd3;
    rf_if.rt_addr = REG_SP;
    #1;
    check("rst_vs_write_r3", rf_if.rs_data, 32'h0);
    check("rst_clears_sp", rf_if.rt_data, 32'h0);
    @(negedge clk);
    rf_if.reg_write = 1'b0;
    rst_n           = 1'b1;
    do_write(5'd3, 32'h77);
    rf_if.rs_addr = 5'd3;
    #1;
    check("r3_after_rst", rf_if.rs_data, 32'h77);

    // Randomized traffic against the model; reads are checked before each
    // edge, so a write to a read index must still show the old value.
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      @(negedge clk);
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom();
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 7) == 0) ? ra : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = wa;
      rf_if.reg_write = we;
      rf_if.wr_addr   = wa;
      rf_if.wr_data   = wd;
      check_pair("rand", ra, rb);
      @(posedge clk);
      if (we && wa != 5'd0) model[wa] = wd;
    end
    @(negedge clk);
    rf_if.reg_write = 1'b0;

    // Final sweep of the whole file.
    for (int i = 0; i < 32; i++) begin
      rf_if.rs_addr = 5'(i);
      rf_if.rt_addr = 5'(31 - i);
      #0.1;
      check("sweep_rs", rf_if.rs_data, model[i]);
      check("sweep_rt", rf_if.rt_data, model[31 - i]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mips_register_file
